// File: rtl/jacobi_scheduler.sv
// jacobi_scheduler: sample-rate sequencer for the iterative Jacobi solver.
// Snapshots A/b once per sample tick, runs up to MAX_ITER solver sweeps,
// publishes x, and flags overruns and hung solvers.
// Optional early exit on convergence: define JACOBI_CONVERGE_EN.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | waiting for a sample tick
// LOAD     | solver latches the A,b snapshot; sweep counter cleared
// START    | one-cycle sweep_start strobe; watchdog cleared
// WAIT     | waiting for sweep_done, watchdog running
// PUBLISH  | x_out/iter_count hold the new sample; x_valid strobe
module jacobi_scheduler #(
    parameter int SIZE        = 3,
    parameter int PRECISION   = 16,
    parameter int POINT       = 8,
    parameter int CLOCK_SPEED = 10000000,
    parameter int SAMPLE_RATE = 48000,
    parameter int MAX_ITER    = 8,
    parameter int TIMEOUT     = 64,
    parameter int EPS         = 1
) (
    input  logic                               clk,
    input  logic                               I_RSTn,
    output logic                               load,
    output logic                               sweep_start,
    input  logic                               sweep_done,
    input  logic [SIZE-1:0][PRECISION+POINT:0] x_in,
    output logic [SIZE-1:0][PRECISION+POINT:0] x_out,
    output logic                               x_valid,
    output logic                               busy,
    output logic [3:0]                         iter_count,
    output logic [7:0]                         overrun_cnt,
    output logic                               timeout_err
);
    localparam int DIV = CLOCK_SPEED / SAMPLE_RATE;
    localparam int CW  = $clog2(DIV);
    localparam int WDW = $clog2(TIMEOUT + 1);

    if (DIV < 8 || MAX_ITER < 1 || MAX_ITER > 15 || TIMEOUT < 1 || EPS < 0) begin : g_param_check
        $error("jacobi_scheduler: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT,
        S_PUBLISH
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    tick_cnt;
    logic             tick;
    logic [WDW-1:0]   wdog;
    logic             wdog_tc;
    logic [3:0]       iter;
    logic [3:0]       iter_nxt;
    logic             converged;
    logic             last_sweep;
    logic             overrun;

    assign tick       = (tick_cnt == CW'(DIV - 1));
    assign wdog_tc    = (wdog == WDW'(TIMEOUT - 1));
    assign iter_nxt   = iter + 4'd1;
    assign last_sweep = (iter_nxt == 4'(MAX_ITER)) || converged;

    // Free-running sample tick divider, wraps after DIV cycles.
    always_ff @(posedge clk) begin
        if (!I_RSTn) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!I_RSTn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and per-state strobes.
    always_comb begin
        state_nxt   = state;
        load        = 1'b0;
        sweep_start = 1'b0;
        x_valid     = 1'b0;
        overrun     = 1'b0;
        busy        = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (tick) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                load      = 1'b1;
                overrun   = tick;
                state_nxt = S_START;
            end
            S_START: begin
                sweep_start = 1'b1;
                overrun     = tick;
                state_nxt   = S_WAIT;
            end
            S_WAIT: begin
                overrun = tick;
                // A sweep_done on the watchdog's last cycle still counts.
                if (sweep_done) begin
                    state_nxt = last_sweep ? S_PUBLISH : S_START;
                end else if (wdog_tc) begin
                    state_nxt = S_IDLE;
                end
            end
            S_PUBLISH: begin
                x_valid   = 1'b1;
                // A tick landing here is not lost: go straight to the next sample.
                state_nxt = tick ? S_LOAD : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Sweep counter, watchdog, published result and status flags.
    // x_out/iter_count are captured on the final sweep_done so they are
    // already valid in the cycle x_valid is high.
    always_ff @(posedge clk) begin
        if (!I_RSTn) begin
            iter        <= '0;
            wdog        <= '0;
            x_out       <= '0;
            iter_count  <= '0;
            overrun_cnt <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state == S_LOAD) iter <= '0;
            if (state == S_START) begin
                wdog <= '0;
            end else if (state == S_WAIT) begin
                wdog <= wdog + 1'b1;
            end
            if (state == S_WAIT && sweep_done) begin
                iter <= iter_nxt;
                if (last_sweep) begin
                    x_out      <= x_in;
                    iter_count <= iter_nxt;
                end
            end
            if (state == S_WAIT && !sweep_done && wdog_tc) timeout_err <= 1'b1;
            if (overrun && overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
        end
    end

`ifdef JACOBI_CONVERGE_EN
    localparam int W = PRECISION + POINT + 1;
    localparam logic signed [W:0] EPS_W = (W + 1)'(EPS);

    logic [SIZE-1:0][W-1:0] x_prev;

    // Differences are taken one bit wider than the word so they never wrap.
    function automatic logic within_eps(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [W:0] d;
        d = $signed({a[W-1], a}) - $signed({b[W-1], b});
        return (d <= EPS_W) && (d >= -EPS_W);
    endfunction

    // Previous sweep result for the convergence test.
    always_ff @(posedge clk) begin
        if (!I_RSTn) begin
            x_prev <= '0;
        end else if (state == S_WAIT && sweep_done) begin
            x_prev <= x_in;
        end
    end

    // Converged once every unknown moved by at most EPS, from the second sweep on.
    always_comb begin
        converged = (iter_nxt >= 4'd2);
        for (int i = 0; i < SIZE; i++) begin
            if (!within_eps(x_in[i], x_prev[i])) converged = 1'b0;
        end
    end
`else
    assign converged = 1'b0;
`endif

endmodule

// File: tb/tb_jacobi_scheduler.sv
// Self-checking bench for jacobi_scheduler (DIV=10, MAX_ITER=4, TIMEOUT=16).
module tb_jacobi_scheduler;
    localparam int SIZE      = 3;
    localparam int PRECISION = 16;
    localparam int POINT     = 8;
    localparam int W         = PRECISION + POINT + 1;
    localparam int DIV       = 10;
    localparam int MAX_ITER  = 4;
    localparam int TIMEOUT   = 16;
    localparam int NSAMP     = 8;

    typedef logic [SIZE-1:0][W-1:0] vec_t;

    typedef struct {
        int   c;
        vec_t x;
        int   it;
        int   ov;
    } pub_t;

    typedef struct {
        int delay;
        int exp_pub;
        int exp_ovr;
        int exp_next_load;
    } vec_rec_t;

    logic       clk = 1'b0;
    logic       I_RSTn = 1'b0;
    logic       load, sweep_start, sweep_done, x_valid, busy, timeout_err;
    vec_t       x_in, x_out;
    logic [3:0] iter_count;
    logic [7:0] overrun_cnt;

    jacobi_scheduler #(
        .SIZE(SIZE), .PRECISION(PRECISION), .POINT(POINT),
        .CLOCK_SPEED(480), .SAMPLE_RATE(48),
        .MAX_ITER(MAX_ITER), .TIMEOUT(TIMEOUT), .EPS(1)
    ) dut (
        .clk(clk), .I_RSTn(I_RSTn), .load(load), .sweep_start(sweep_start),
        .sweep_done(sweep_done), .x_in(x_in), .x_out(x_out), .x_valid(x_valid),
        .busy(busy), .iter_count(iter_count), .overrun_cnt(overrun_cnt),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   cyc;
    int   pending;
    int   stray_cyc;
    int   const_delay;
    bit   use_rand;
    int   xmode;
    int   dq[$];
    vec_t done_x[$];
    int   load_q[$];
    pub_t pub_q[$];
    vec_t XF;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: expected event missing (cycle %0d)", name, cyc);
    endtask

    function automatic bit is_tick(input int c);
        return (c % DIV) == DIV - 1;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        for (int i = 0; i < SIZE; i++) v[i] = W'($urandom());
        return v;
    endfunction

    // Sweep k of a sample walks towards XF in 0x40 steps, so it never looks converged.
    function automatic vec_t sweep_val(input int k);
        vec_t v;
        for (int i = 0; i < SIZE; i++) v[i] = XF[i] + W'((MAX_ITER - 1 - k) * 64);
        return v;
    endfunction

    // One clock: observe DUT outputs #1 after the edge, then drive the solver model.
    task automatic step();
        int   d;
        pub_t p;
        @(posedge clk);
        #1;
        cyc++;
        if (load) load_q.push_back(cyc);
        if (x_valid) begin
            p.c  = cyc;
            p.x  = x_out;
            p.it = int'(iter_count);
            p.ov = int'(overrun_cnt);
            pub_q.push_back(p);
        end
        if (sweep_start) begin
            if (use_rand) d = (dq.size() > 0) ? dq.pop_front() : 1;
            else          d = const_delay;
            if (d > 0) pending = cyc + d;
        end
        if (cyc == pending) begin
            sweep_done = 1'b1;
            case (xmode)
                0:       x_in = sweep_val(done_x.size() % MAX_ITER);
                1:       x_in = rand_vec();
                default: x_in = XF;
            endcase
            done_x.push_back(x_in);
        end else begin
            sweep_done = (cyc == stray_cyc);
            x_in       = rand_vec();
        end
    endtask

    task automatic clear_logs();
        load_q.delete();
        pub_q.delete();
        done_x.delete();
        dq.delete();
        pending   = -1;
        stray_cyc = -1;
    endtask

    // Leaves the bench in cycle 0 (first cycle after release, tick counter 0).
    task automatic do_reset();
        I_RSTn     = 1'b0;
        sweep_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ctrl", {load, sweep_start, x_valid, busy, timeout_err, iter_count, overrun_cnt}, '0);
        chk("rst_x_out", x_out, '0);
        clear_logs();
        cyc    = 0;
        I_RSTn = 1'b1;
    endtask

    vec_rec_t tbl[5];
    int       s_cyc, n, c, L, t, P, ovr, d;
    bit       early;
    int       exp_load[NSAMP];
    int       exp_pub[NSAMP];
    int       exp_ovr[NSAMP];

    initial begin
        XF[0] = W'(256);
        XF[1] = W'(-128);
        XF[2] = W'(64);
        x_in       = '0;
        sweep_done = 1'b0;
        use_rand   = 1'b0;
        xmode      = 0;
        const_delay = 4;
        cyc = 0;
        clear_logs();

        // Constant solver delay: {delay, publish cycle, overruns, next load cycle}.
        tbl[0] = '{1,  19, 0, 20};
        tbl[1] = '{2,  23, 1, 30};
        tbl[2] = '{4,  31, 2, 40};
        tbl[3] = '{6,  39, 2, 40};
        tbl[4] = '{16, 79, 6, 80};

        for (int i = 0; i < 5; i++) begin
            do_reset();
            use_rand    = 1'b0;
            xmode       = 0;
            const_delay = tbl[i].delay;
            for (int k = 0; k < 300 && !(pub_q.size() >= 1 && load_q.size() >= 2); k++) step();
            if (pub_q.size() < 1 || load_q.size() < 2) begin
                fail($sformatf("tbl%0d_events", i));
            end else begin
                chk($sformatf("tbl%0d_first_load", i), load_q[0], DIV);
                chk($sformatf("tbl%0d_pub_cyc", i), pub_q[0].c, tbl[i].exp_pub);
                chk($sformatf("tbl%0d_x_out", i), pub_q[0].x, XF);
                chk($sformatf("tbl%0d_iter", i), pub_q[0].it, MAX_ITER);
                chk($sformatf("tbl%0d_ovr", i), pub_q[0].ov, tbl[i].exp_ovr);
                chk($sformatf("tbl%0d_next_load", i), load_q[1], tbl[i].exp_next_load);
                chk($sformatf("tbl%0d_sweeps", i), done_x.size() >= MAX_ITER, 1);
                chk($sformatf("tbl%0d_no_timeout", i), timeout_err, 0);
            end
        end

        // Solver never answers: watchdog fires, nothing is published.
        do_reset();
        const_delay = -1;
        for (int k = 0; k < 100 && !sweep_start; k++) step();
        s_cyc = cyc;
        chk("to_start_cyc", s_cyc, DIV + 1);
        early = 1'b0;
        repeat (TIMEOUT) begin
            step();
            if (timeout_err) early = 1'b1;
        end
        chk("to_not_early", early, 0);
        step();
        chk("to_err", timeout_err, 1);
        chk("to_busy", busy, 0);
        chk("to_ovr", overrun_cnt, 1);
        repeat (40) step();
        chk("to_no_valid", pub_q.size(), 0);
        chk("to_sticky", timeout_err, 1);

        // Reset pulse mid-WAIT, then a stray sweep_done while IDLE.
        do_reset();
        const_delay = 6;
        xmode       = 0;
        for (int k = 0; k < 50 && cyc < 14; k++) step();
        chk("rw_busy", busy, 1);
        I_RSTn = 1'b0;
        step();
        chk("rw_ctrl", {load, sweep_start, x_valid, busy, timeout_err, iter_count, overrun_cnt}, '0);
        chk("rw_x_out", x_out, '0);
        clear_logs();
        cyc       = 0;
        I_RSTn    = 1'b1;
        stray_cyc = 3;
        for (int k = 0; k < 80 && pub_q.size() == 0; k++) step();
        stray_cyc = -1;
        if (pub_q.size() == 0 || load_q.size() == 0) begin
            fail("rw_events");
        end else begin
            chk("rw_first_load", load_q[0], DIV);
            chk("rw_pub_cyc", pub_q[0].c, 39);
            chk("rw_iter", pub_q[0].it, MAX_ITER);
            chk("rw_x_out_pub", pub_q[0].x, XF);
        end

        // Random solver delays against a timeline model.
        do_reset();
        use_rand = 1'b1;
        xmode    = 1;
        L   = DIV;
        ovr = 0;
        for (int s = 0; s < NSAMP; s++) begin
            exp_load[s] = L;
            t = L + 1;
            for (int k = 0; k < MAX_ITER; k++) begin
                d = $urandom_range(1, 7);
                dq.push_back(d);
                t = t + d + 1;
            end
            P = t;
            for (int cc = L; cc < P; cc++) if (is_tick(cc)) ovr++;
            if (ovr > 255) ovr = 255;
            exp_pub[s] = P;
            exp_ovr[s] = ovr;
            if (is_tick(P)) begin
                L = P + 1;
            end else begin
                c = P + 1;
                while (!is_tick(c)) c++;
                L = c + 1;
            end
        end
        for (int k = 0; k < 1500 && pub_q.size() < NSAMP; k++) step();
        for (int s = 0; s < NSAMP; s++) begin
            if (s >= pub_q.size() || s >= load_q.size()) begin
                fail($sformatf("rnd%0d_events", s));
            end else begin
                chk($sformatf("rnd%0d_load", s), load_q[s], exp_load[s]);
                chk($sformatf("rnd%0d_pub", s), pub_q[s].c, exp_pub[s]);
                chk($sformatf("rnd%0d_iter", s), pub_q[s].it, MAX_ITER);
                chk($sformatf("rnd%0d_ovr", s), pub_q[s].ov, exp_ovr[s]);
                chk($sformatf("rnd%0d_x", s), pub_q[s].x, done_x[(s + 1) * MAX_ITER - 1]);
            end
        end
        use_rand = 1'b0;

`ifdef JACOBI_CONVERGE_EN
        // Identical result on every sweep: converges on the second sweep.
        do_reset();
        const_delay = 4;
        xmode       = 2;
        for (int k = 0; k < 200 && pub_q.size() == 0; k++) step();
        if (pub_q.size() == 0) begin
            fail("cv_events");
        end else begin
            chk("cv_pub_cyc", pub_q[0].c, 21);
            chk("cv_iter", pub_q[0].it, 2);
            chk("cv_x_out", pub_q[0].x, XF);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_time_limit: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
